// File: rtl/soi_pkg.sv
// Shared types and constants for the signal-of-interest event capture block.
package soi_pkg;

    localparam int DROP_W    = 16;
    localparam int SOI_W_DEF = 8;
    localparam int TS_W_DEF  = 32;

    // Event record at the default widths; parameterised builds use a local copy with the same fields.
    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [SOI_W_DEF-1:0] val;
    } soi_event_t;

endpackage

// File: rtl/soi_fifo.sv
// Synchronous FIFO for captured events; simultaneous push and pop are allowed when full.
module soi_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       din,
    output logic                   full,
    input  logic                   pop,
    output T                       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Read port shows zero while empty so nothing stale leaks out after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/soi_event_capture.sv
// Timestamps changes on a sampled signal of interest and queues them for a drain consumer.
module soi_event_capture
    import soi_pkg::*;
#(
    parameter int SOI_W = 8,
    parameter int TS_W  = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic [SOI_W-1:0]       soi,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [TS_W-1:0]        ev_ts,
    output logic [SOI_W-1:0]       ev_val,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic [$clog2(DEPTH):0] level
);
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [SOI_W-1:0] val;
    } ev_t;

    logic [TS_W-1:0]  ts_cnt;
    logic [SOI_W-1:0] soi_q;
    logic [SOI_W-1:0] soi_prev;
    logic             arm_q;
    logic             arm_prev;
    logic             pend_v;
    ev_t              pend_ev;
    ev_t              head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready;
    assign drop     = pend_v && fifo_full && !pop;
    assign ev_ts    = head.ts;
    assign ev_val   = head.val;

    // arm is sampled alongside soi so both describe the same cycle; arm_prev low marks an arm rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt   <= '0;
            soi_q    <= '0;
            soi_prev <= '0;
            arm_q    <= 1'b0;
            arm_prev <= 1'b0;
            pend_v   <= 1'b0;
            pend_ev  <= '0;
            drop_cnt <= '0;
        end else begin
            ts_cnt     <= ts_cnt + TS_W'(1);
            soi_q      <= soi;
            soi_prev   <= soi_q;
            arm_q      <= arm;
            arm_prev   <= arm_q;
            pend_v     <= arm_q && (!arm_prev || (soi_q != soi_prev));
            pend_ev.ts <= ts_cnt;
            pend_ev.val <= soi_q;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    soi_fifo #(
        .T     (ev_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_v),
        .din   (pend_ev),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_soi_event_capture.sv
// Directed bench for soi_event_capture: per-cycle vector table plus fill, reset and timestamp-wrap sequences.
module tb_soi_event_capture;
    import soi_pkg::*;

    logic        clk;
    logic        rst;
    logic        arm;
    logic [7:0]  soi;
    logic        rdy;
    logic        ev_valid;
    logic [31:0] ev_ts;
    logic [7:0]  ev_val;
    logic [15:0] drop_cnt;
    logic [4:0]  level;

    logic        rst4;
    logic        arm4;
    logic [7:0]  soi4;
    logic        rdy4;
    logic        ev_valid4;
    logic [3:0]  ev_ts4;
    logic [7:0]  ev_val4;
    logic [15:0] drop4;
    logic [2:0]  level4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int got4   = 0;

    soi_event_t       exp_q[$];
    logic [11:0]      q4[$];

    soi_event_capture #(.SOI_W(8), .TS_W(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .arm(arm), .soi(soi), .ev_valid(ev_valid), .ev_ready(rdy),
        .ev_ts(ev_ts), .ev_val(ev_val), .drop_cnt(drop_cnt), .level(level)
    );

    soi_event_capture #(.SOI_W(8), .TS_W(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst4), .arm(arm4), .soi(soi4), .ev_valid(ev_valid4), .ev_ready(rdy4),
        .ev_ts(ev_ts4), .ev_val(ev_val4), .drop_cnt(drop4), .level(level4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm;
        logic [7:0]  soi;
        logic        rdy;
        logic        valid;
        logic [31:0] ts;
        logic [7:0]  val;
        logic [4:0]  level;
        logic [15:0] drop;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input bit a, input int s, input bit r, input bit v,
                                input int t, input int vl, input int lv, input int d);
        vec_t m;
        m.arm   = a;
        m.soi   = 8'(s);
        m.rdy   = r;
        m.valid = v;
        m.ts    = 32'(t);
        m.val   = 8'(vl);
        m.level = 5'(lv);
        m.drop  = 16'(d);
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        arm = 1'b0;
        soi = 8'h00;
        rdy = 1'b0;
        step();
        step();
        chk("reset_state", 64'({ev_valid, ev_ts, ev_val, level, drop_cnt}), 64'(0));
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic mon4;
        if (ev_valid4) begin
            if (q4.size() == 0) begin
                chk("ts4_extra_event", 64'(ev_valid4), 64'(0));
            end else begin
                chk("ts4_event", 64'({ev_ts4, ev_val4}), 64'(q4[0]));
                void'(q4.pop_front());
                got4++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst4 = 1'b1;
        arm4 = 1'b0;
        soi4 = 8'h00;
        rdy4 = 1'b0;

        //             arm  soi  rdy  valid ts  val  lvl drop
        vecs[0]  = mk(1, 'h00, 1, 0,  0, 'h00, 0, 0);
        vecs[1]  = mk(1, 'h00, 1, 0,  0, 'h00, 0, 0);
        vecs[2]  = mk(1, 'h00, 1, 1,  1, 'h00, 1, 0);
        vecs[3]  = mk(1, 'h00, 1, 0,  0, 'h00, 0, 0);
        vecs[4]  = mk(1, 'h5A, 1, 0,  0, 'h00, 0, 0);
        vecs[5]  = mk(1, 'h5A, 1, 0,  0, 'h00, 0, 0);
        vecs[6]  = mk(1, 'hA5, 1, 1,  5, 'h5A, 1, 0);
        vecs[7]  = mk(1, 'hA5, 1, 0,  0, 'h00, 0, 0);
        vecs[8]  = mk(1, 'hA5, 1, 1,  7, 'hA5, 1, 0);
        vecs[9]  = mk(1, 'hA5, 1, 0,  0, 'h00, 0, 0);
        vecs[10] = mk(0, 'hA5, 1, 0,  0, 'h00, 0, 0);
        vecs[11] = mk(0, 'h3C, 1, 0,  0, 'h00, 0, 0);
        vecs[12] = mk(0, 'h3C, 1, 0,  0, 'h00, 0, 0);
        vecs[13] = mk(1, 'h3C, 1, 0,  0, 'h00, 0, 0);
        vecs[14] = mk(1, 'h3C, 1, 0,  0, 'h00, 0, 0);
        vecs[15] = mk(1, 'h3C, 0, 1, 14, 'h3C, 1, 0);
        vecs[16] = mk(1, 'h3C, 0, 1, 14, 'h3C, 1, 0);
        vecs[17] = mk(1, 'h3C, 1, 0,  0, 'h00, 0, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            arm = vecs[i].arm;
            soi = vecs[i].soi;
            rdy = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d", i),
                64'({ev_valid, ev_ts, ev_val, level, drop_cnt}),
                64'({vecs[i].valid, vecs[i].ts, vecs[i].val, vecs[i].level, vecs[i].drop}));
        end

        // Fill with 20 events while stalled: 16 stored, 4 dropped.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            arm = 1'b1;
            rdy = 1'b0;
            soi = 8'(i + 1);
            step();
            if (i < 16) exp_q.push_back('{ts: 32'(cyc), val: 8'(i + 1)});
        end
        for (int i = 0; i < 3; i++) step();
        chk("fill_level", 64'(level), 64'(16));
        chk("fill_drop", 64'(drop_cnt), 64'(4));
        chk("fill_head", 64'({ev_valid, ev_ts, ev_val}), 64'({1'b1, exp_q[0]}));

        // New event lands on the same edge as a pop while full.
        soi = 8'h80;
        step();
        exp_q.push_back('{ts: 32'(cyc), val: 8'h80});
        step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        void'(exp_q.pop_front());
        chk("full_pushpop_level", 64'(level), 64'(16));
        chk("full_pushpop_drop", 64'(drop_cnt), 64'(4));
        chk("full_pushpop_head", 64'({ev_valid, ev_ts, ev_val}), 64'({1'b1, exp_q[0]}));

        rdy = 1'b1;
        for (int b = 0; b < 60 && exp_q.size() > 0; b++) begin
            if (ev_valid) begin
                chk("drain_order", 64'({ev_ts, ev_val}), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            step();
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'(0));
        chk("drain_level", 64'({ev_valid, level}), 64'(0));

        // Queue five, deassert arm (no flush), then reset with an event in flight.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            arm = 1'b1;
            rdy = 1'b0;
            soi = 8'(8'h10 + i);
            step();
        end
        for (int i = 0; i < 3; i++) step();
        chk("five_level", 64'(level), 64'(5));
        arm = 1'b0;
        soi = 8'h55;
        step();
        step();
        step();
        chk("disarm_keeps", 64'({level, ev_valid, ev_ts, ev_val}), 64'({5'd5, 1'b1, 32'd1, 8'h10}));
        arm = 1'b1;
        soi = 8'h99;
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_state", 64'({ev_valid, ev_ts, ev_val, level, drop_cnt}), 64'(0));
        rst = 1'b0;
        soi = 8'h77;
        cyc = 0;
        step();
        chk("midrst_no_inflight1", 64'(level), 64'(0));
        step();
        chk("midrst_no_inflight2", 64'(level), 64'(0));
        step();
        chk("midrst_first_event", 64'({ev_valid, ev_ts, ev_val, level}), 64'({1'b1, 32'd1, 8'h77, 5'd1}));

        // Narrow timestamp: toggle every cycle across a 15 -> 0 wrap, nothing lost.
        arm  = 1'b0;
        rdy  = 1'b1;
        rst4 = 1'b0;
        arm4 = 1'b1;
        rdy4 = 1'b1;
        cyc  = 0;
        for (int i = 0; i < 24; i++) begin
            soi4 = i[0] ? 8'hFF : 8'h00;
            step();
            q4.push_back({4'(cyc), soi4});
            mon4();
        end
        for (int i = 0; i < 6; i++) begin
            step();
            mon4();
        end
        chk("ts4_count", 64'(got4), 64'(24));
        chk("ts4_drop_level", 64'({drop4, level4}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
